// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared widths and the store-buffer entry layout for the data-memory path.
package mips_mem_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WORD_LSB = 2;
    typedef struct packed {
        logic [ADDR_W-WORD_LSB-1:0] word_addr;
        logic [DATA_W-1:0]          data;
    } sb_entry_t;
endpackage

// File: rtl/mips_sb_fifo.sv
// mips_sb_fifo: circular store FIFO with head/tail pointers and an occupancy count.
module mips_sb_fifo
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_i,
    input  sb_entry_t             push_entry_i,
    input  logic                  pop_i,
    output sb_entry_t             head_o,
    output sb_entry_t [DEPTH-1:0] entries_o,
    output logic [PTR_W-1:0]      head_ptr_o,
    output logic [PTR_W:0]        count_o,
    output logic                  full_o,
    output logic                  empty_o
);
    sb_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0] count_q, count_d;
    always_comb begin
        count_d = count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + 1'b1;
            if (pop_i) head_q <= head_q + 1'b1;
            count_q <= count_d;
        end
    end
    // Payload needs no reset: count gates every read of it.
    always_ff @(posedge clock) begin
        if (push_i) mem_q[tail_q] <= push_entry_i;
    end
    assign head_o     = mem_q[head_q];
    assign entries_o  = mem_q;
    assign head_ptr_o = head_q;
    assign count_o    = count_q;
    assign full_o     = count_q == (PTR_W+1)'(DEPTH);
    assign empty_o    = count_q == '0;
endmodule

// File: rtl/mips_store_buffer.sv
// mips_store_buffer: posted-write buffer in front of data memory with load forwarding,
// load-priority port arbitration and flush-to-empty stalling.
module mips_store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_write_data,
    input  logic              cpu_mem_read,
    input  logic              cpu_mem_write,
    output logic [DATA_W-1:0] cpu_read_data,
    output logic              cpu_stall,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              sig_mem_read,
    output logic              sig_mem_write,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              buf_empty,
    output logic [PTR_W:0]    buf_count
);
    sb_entry_t [DEPTH-1:0] entries;
    sb_entry_t head_entry;
    logic [PTR_W-1:0] head_ptr, idx;
    logic full, empty, drain_fire, push, fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    mips_sb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push),
        .push_entry_i('{word_addr: cpu_address[ADDR_W-1:WORD_LSB], data: cpu_write_data}),
        .pop_i       (drain_fire),
        .head_o      (head_entry),
        .entries_o   (entries),
        .head_ptr_o  (head_ptr),
        .count_o     (buf_count),
        .full_o      (full),
        .empty_o     (empty)
    );
    // A load owns the memory port; drains only use otherwise idle cycles.
    assign drain_fire = !reset && !cpu_mem_read && !empty;
    assign cpu_stall  = !reset && ((cpu_mem_write && full && !drain_fire) ||
                                   (flush && (!empty || cpu_mem_write)));
    assign push           = !reset && cpu_mem_write && !cpu_stall;
    assign sig_mem_read   = !reset && cpu_mem_read;
    assign sig_mem_write  = drain_fire;
    assign mem_address    = sig_mem_read ? cpu_address :
                            drain_fire ? {head_entry.word_addr, {WORD_LSB{1'b0}}} : '0;
    assign mem_write_data = drain_fire ? head_entry.data : '0;
    assign buf_empty      = empty;
    // Oldest-to-youngest scan so the last hit is the youngest matching store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_ptr + PTR_W'(i);
            if ((PTR_W+1)'(i) < buf_count && entries[idx].word_addr == cpu_address[ADDR_W-1:WORD_LSB]) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[idx].data;
            end
        end
    end
    assign cpu_read_data = fwd_hit ? fwd_data : mem_read_data;
endmodule

// File: tb/tb_mips_store_buffer.sv
// tb_mips_store_buffer: directed stimulus with a write scoreboard checked by a separate monitor.
module tb_mips_store_buffer;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] cpu_address, cpu_write_data, cpu_read_data;
    logic        cpu_mem_read, cpu_mem_write, cpu_stall, flush;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        sig_mem_read, sig_mem_write, buf_empty;
    logic [2:0]  buf_count;
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_wr_q[$];

    mips_store_buffer #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset), .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write), .cpu_read_data(cpu_read_data),
        .cpu_stall(cpu_stall), .flush(flush), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .sig_mem_read(sig_mem_read), .sig_mem_write(sig_mem_write), .mem_read_data(mem_read_data),
        .buf_empty(buf_empty), .buf_count(buf_count)
    );

    always #5 clock = ~clock;
    assign mem_read_data = ~mem_address;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (sig_mem_write) begin
            logic [63:0] e;
            if (exp_wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_address, mem_write_data);
            end else begin
                e = exp_wr_q.pop_front();
                chk("drain_addr", mem_address, e[63:32]);
                chk("drain_data", mem_write_data, e[31:0]);
            end
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic fl, input logic [31:0] a, input logic [31:0] d);
        cpu_mem_read = rd; cpu_mem_write = wr; flush = fl; cpu_address = a; cpu_write_data = d;
    endtask

    task automatic to_neg;
        @(negedge clock);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int stall_cycles;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        to_neg;
        chk("reset_stall", 32'(cpu_stall), 0);
        chk("reset_wr", 32'(sig_mem_write), 0);
        tick; tick;
        reset = 1'b0;
        chk("reset_count", 32'(buf_count), 0);
        chk("reset_empty", 32'(buf_empty), 1);
        // store queued, drains next idle cycle
        drive(0, 1, 0, 32'h10, 32'h1111_1111);
        exp_wr_q.push_back({32'h10, 32'h1111_1111});
        to_neg;
        chk("t1_no_bypass", 32'(sig_mem_write), 0);
        tick;
        chk("t1_count1", 32'(buf_count), 1);
        drive(0, 0, 0, 0, 0);
        to_neg;
        chk("t1_wr_strobe", 32'(sig_mem_write), 1);
        tick;
        chk("t1_count0", 32'(buf_count), 0);
        // duplicate addresses while loads hold the port
        drive(1, 1, 0, 32'h20, 32'hAAAA_0000);
        exp_wr_q.push_back({32'h20, 32'hAAAA_0000});
        to_neg;
        chk("t2_prepush_miss", cpu_read_data, 32'hFFFF_FFDF);
        tick;
        drive(1, 1, 0, 32'h20, 32'hBBBB_0000);
        exp_wr_q.push_back({32'h20, 32'hBBBB_0000});
        to_neg;
        chk("t2_prepush_fwd", cpu_read_data, 32'hAAAA_0000);
        tick;
        drive(1, 0, 0, 32'h22, 0);
        to_neg;
        chk("t2_youngest", cpu_read_data, 32'hBBBB_0000);
        chk("t2_no_drain", 32'(sig_mem_write), 0);
        chk("t2_rd_strobe", 32'(sig_mem_read), 1);
        tick;
        drive(1, 0, 0, 32'h80, 0);
        to_neg;
        chk("t5_miss_data", cpu_read_data, 32'hFFFF_FF7F);
        chk("t5_rd_addr", mem_address, 32'h80);
        tick;
        // fill to DEPTH under loads
        drive(1, 1, 0, 32'h30, 32'h3333_3333);
        exp_wr_q.push_back({32'h30, 32'h3333_3333});
        tick;
        drive(1, 1, 0, 32'h34, 32'h4444_4444);
        exp_wr_q.push_back({32'h34, 32'h4444_4444});
        tick;
        chk("t3_full", 32'(buf_count), 4);
        drive(1, 1, 0, 32'h40, 32'h5555_5555);
        to_neg;
        chk("t4_rdwr_stall", 32'(cpu_stall), 1);
        chk("t4_no_pop", 32'(sig_mem_write), 0);
        tick;
        chk("t4_unchanged", 32'(buf_count), 4);
        drive(0, 1, 0, 32'h40, 32'h5555_5555);
        exp_wr_q.push_back({32'h40, 32'h5555_5555});
        to_neg;
        chk("t3_no_stall", 32'(cpu_stall), 0);
        chk("t3_drain_same", 32'(sig_mem_write), 1);
        tick;
        chk("t3_count_kept", 32'(buf_count), 4);
        drive(0, 0, 0, 0, 0);
        tick;
        chk("t6_pre_flush", 32'(buf_count), 3);
        // flush drains the remaining three
        drive(0, 0, 1, 0, 0);
        stall_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            to_neg;
            if (!cpu_stall) break;
            stall_cycles++;
            tick;
        end
        chk("t6_stall_cycles", 32'(stall_cycles), 3);
        chk("t6_empty", 32'(buf_empty), 1);
        chk("t6_stall_low", 32'(cpu_stall), 0);
        tick;
        // reset discards pending stores
        drive(1, 1, 0, 32'h60, 32'h6666_6666);
        tick;
        drive(1, 1, 0, 32'h64, 32'h7777_7777);
        tick;
        drive(1, 0, 0, 32'h60, 0);
        to_neg;
        chk("t6_two_queued", 32'(buf_count), 2);
        tick;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        to_neg;
        chk("t6_reset_nowr", 32'(sig_mem_write), 0);
        tick;
        reset = 1'b0;
        chk("t6_reset_count", 32'(buf_count), 0);
        for (int i = 0; i < 3; i++) begin
            to_neg;
            chk("t6_post_reset_nowr", 32'(sig_mem_write), 0);
            tick;
        end
        chk("sb_drained", 32'(exp_wr_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
